// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-byte adder sequencer driving one shared external 8-bit adder.
// Optional macro ADD_SEQ_OVF_EN adds a registered signed-overflow flag output (ovf).
module multibyte_add_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
`ifdef ADD_SEQ_OVF_EN
  output logic                  ovf,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IDXW+2:0] bit_ofs;

  // Bit offset of the byte currently being processed.
  assign bit_ofs = {idx_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, operand latching and byte capture.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = 8'h00;
    add_b    = 8'h00;
    add_cin  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        add_a   = a_q[bit_ofs +: 8];
        add_b   = b_q[bit_ofs +: 8];
        add_cin = carry_q;
        result_d[bit_ofs +: 8] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          // Signed overflow: like-signed operands, sum sign differs.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;

`ifdef ADD_SEQ_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
